// File: rtl/l2_ic_refill.sv
// l2_ic_refill
// L2-side responder for instruction-cache miss refills. It accepts a level
// request (irq) from the icache and fetches the 4-word line containing
// if_addr from a word-serial memory bus. It reports the line ready (L2_rdy),
// waits for the icache to release irq, writes the line into the L1 array
// (l1_wr_en), and then pulses complete.
//
// Ports
//   clk, rst          clock and asynchronous active-low reset
//   irq, if_addr      icache request level and miss address
//   L2_busy, L2_rdy   responder busy / line assembled
//   complete          one-cycle pulse after the L1 write
//   l1_data_wd        assembled line, word k at bits [32k+31:32k]
//   l1_valid_wd       valid bit for the line (0 if any beat timed out)
//   l1_wr_en          one-cycle L1 write strobe
//   mem_req/mem_addr  memory read request and word address of current beat
//   mem_ack/mem_rdata memory read data strobe and data
//   refill_err        sticky: some beat timed out since reset
module l2_ic_refill #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] RST_DATA    = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         irq,
  input  logic [31:0]  if_addr,
  output logic         L2_busy,
  output logic         L2_rdy,
  output logic         complete,
  output logic [127:0] l1_data_wd,
  output logic         l1_valid_wd,
  output logic         l1_wr_en,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_ack,
  input  logic [31:0]  mem_rdata,
  output logic         refill_err
);

  localparam int unsigned       TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  // GAP is the single idle-bus cycle that follows every beat (including the
  // last one), so each beat costs two cycles with a same-cycle ack.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [31:0]     base_q, base_d;
  logic [1:0]      beat_q, beat_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_line_q, err_line_d;
  logic            refill_err_q, refill_err_d;
  logic            abort_q, abort_d;

  logic            in_fetch;
  logic            beat_end;
  logic            beat_timeout;
  logic            line_out;
  logic [31:0]     beat_word;

  assign in_fetch     = (state_q == S_FETCH);
  // An ack in the cycle the timeout would fire wins: the beat counts as acked.
  assign beat_end     = in_fetch && (mem_ack || (to_cnt_q == TO_LAST));
  assign beat_timeout = in_fetch && !mem_ack && (to_cnt_q == TO_LAST);
  assign beat_word    = mem_ack ? mem_rdata : RST_DATA;
  assign line_out     = (state_q == S_RESP) || (state_q == S_WRITE) || (state_q == S_DONE);

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    beat_d       = beat_q;
    to_cnt_d     = to_cnt_q;
    err_line_d   = err_line_q;
    refill_err_d = refill_err_q;
    abort_d      = abort_q;
    case (state_q)
      S_IDLE: begin
        if (irq) begin
          // Masking keeps the whole address word in use; the low nibble is
          // always zero so base_q is line aligned.
          base_d     = if_addr & 32'hFFFF_FFF0;
          beat_d     = 2'd0;
          to_cnt_d   = '0;
          err_line_d = 1'b0;
          abort_d    = 1'b0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        // A dropped irq is remembered; the outstanding beat still completes.
        if (!irq) abort_d = 1'b1;
        if (beat_end) begin
          to_cnt_d = '0;
          if (beat_timeout) begin
            err_line_d   = 1'b1;
            refill_err_d = 1'b1;
          end
          state_d = (abort_q || !irq) ? S_IDLE : S_GAP;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_GAP: begin
        if (abort_q || !irq) begin
          state_d = S_IDLE;
        end else if (beat_q == 2'd3) begin
          state_d = S_RESP;
        end else begin
          beat_d  = beat_q + 2'd1;
          state_d = S_FETCH;
        end
      end
      S_RESP:  if (!irq) state_d = S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      beat_q       <= '0;
      to_cnt_q     <= '0;
      err_line_q   <= 1'b0;
      refill_err_q <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      beat_q       <= beat_d;
      to_cnt_q     <= to_cnt_d;
      err_line_q   <= err_line_d;
      refill_err_q <= refill_err_d;
      abort_q      <= abort_d;
    end
  end

  // One 32-bit register per line word; the line is only presented while it
  // is being handed to the L1 (RESP through DONE) and reads as zero otherwise.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_word
      logic [31:0] word_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          word_q <= '0;
        end else if (beat_end && (beat_q == 2'(gi))) begin
          word_q <= beat_word;
        end
      end
      assign l1_data_wd[32*gi +: 32] = line_out ? word_q : 32'h0;
    end
  endgenerate

  assign L2_busy     = (state_q != S_IDLE);
  assign L2_rdy      = (state_q == S_RESP);
  assign l1_wr_en    = (state_q == S_WRITE);
  assign complete    = (state_q == S_DONE);
  assign l1_valid_wd = line_out && !err_line_q;
  assign mem_req     = in_fetch;
  assign mem_addr    = in_fetch ? (base_q + {28'd0, beat_q, 2'b00}) : 32'h0;
  assign refill_err  = refill_err_q;

endmodule

// File: tb/tb_l2_ic_refill.sv
// Testbench for l2_ic_refill. A memory responder answers mem_req with a
// per-address data pattern and configurable per-beat delay / no-ack. Each
// request pushes its expected line onto a scoreboard queue; the entry is
// popped and compared when the DUT strobes l1_wr_en.
module tb_l2_ic_refill;

  localparam int unsigned TO   = 8;
  localparam logic [31:0] RSTD = 32'hDEAD_0BAD;

  logic         clk;
  logic         rst;
  logic         irq;
  logic [31:0]  if_addr;
  logic         L2_busy;
  logic         L2_rdy;
  logic         complete;
  logic [127:0] l1_data_wd;
  logic         l1_valid_wd;
  logic         l1_wr_en;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic         refill_err;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [127:0] line;
    logic         valid;
  } exp_t;
  exp_t exp_q[$];

  l2_ic_refill #(.TIMEOUT_CYC(TO), .RST_DATA(RSTD)) dut (
    .clk(clk), .rst(rst), .irq(irq), .if_addr(if_addr),
    .L2_busy(L2_busy), .L2_rdy(L2_rdy), .complete(complete),
    .l1_data_wd(l1_data_wd), .l1_valid_wd(l1_valid_wd), .l1_wr_en(l1_wr_en),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .refill_err(refill_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  // Memory responder: decides mem_ack for the current cycle 1 time unit
  // after each rising edge.
  int slow_beat = -1, slow_delay = 0, noack_beat = -1;
  int wait_cnt = 0, req_run = 0, run_idx = 0, addr_unstable = 0;
  int run_len[4];
  logic [31:0] obs_addr_q[$];
  logic        req_prev = 1'b0;
  logic [31:0] addr_prev = '0;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
  end

  always @(posedge clk) begin
    int idx;
    #1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    if (mem_req === 1'b1) begin
      idx = int'(mem_addr[3:2]);
      if (req_prev && (mem_addr !== addr_prev)) addr_unstable++;
      req_run++;
      run_idx = idx;
      if (idx != noack_beat && wait_cnt >= ((idx == slow_beat) ? slow_delay : 0)) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
        obs_addr_q.push_back(mem_addr);
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      if (req_run > 0) run_len[run_idx] = req_run;
      req_run  = 0;
      wait_cnt = 0;
    end
    req_prev  = mem_req;
    addr_prev = mem_addr;
  end

  // Pulse counters sampled on the falling edge.
  int cnt_wr = 0, cnt_cmp = 0, cnt_rdy = 0, cnt_req = 0;
  always @(negedge clk) begin
    if (l1_wr_en === 1'b1) cnt_wr++;
    if (complete === 1'b1) cnt_cmp++;
    if (L2_rdy === 1'b1)   cnt_rdy++;
    if (mem_req === 1'b1)  cnt_req++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_obs();
    obs_addr_q.delete();
    cnt_wr = 0; cnt_cmp = 0; cnt_rdy = 0; cnt_req = 0;
    addr_unstable = 0;
    for (int k = 0; k < 4; k++) run_len[k] = 0;
  endtask

  // Configures the memory, pushes the expected line and raises irq.
  task automatic start_req(input logic [31:0] addr, input int nb, input int sb, input int sd);
    exp_t e;
    logic [31:0] base;
    noack_beat = nb;
    slow_beat  = sb;
    slow_delay = sd;
    base    = addr & 32'hFFFF_FFF0;
    e.valid = (nb < 0);
    for (int k = 0; k < 4; k++)
      e.line[32*k +: 32] = (k == nb) ? RSTD : mem_word(base + 32'(4 * k));
    exp_q.push_back(e);
    if_addr = addr;
    irq     = 1'b1;
  endtask

  task automatic wait_rdy(output int lat, output bit busy_gap);
    lat = -1;
    busy_gap = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk);
      #1;
      if (L2_busy !== 1'b1) busy_gap = 1'b1;
      if (L2_rdy === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic finish_req(output int wr_lat, output logic [127:0] d, output logic v, output int cmp_lat);
    irq = 1'b0;
    wr_lat = -1; cmp_lat = -1; d = '0; v = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (l1_wr_en === 1'b1 && wr_lat < 0) begin
        wr_lat = c;
        d = l1_data_wd;
        v = l1_valid_wd;
      end
      if (complete === 1'b1) begin
        cmp_lat = c;
        break;
      end
    end
    tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b0; irq = 1'b0; if_addr = '0;
    tick(3);
    tests_run++;
    if ({L2_busy, L2_rdy, complete, l1_wr_en, l1_valid_wd, mem_req, refill_err} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b want 0000000", {L2_busy, L2_rdy, complete, l1_wr_en, l1_valid_wd, mem_req, refill_err});
    end
    tests_run++;
    if (l1_data_wd !== 128'h0 || mem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got data=%h addr=%h want 0", l1_data_wd, mem_addr);
    end
    rst = 1'b1;
    tick(2);
    tests_run++;
    if (L2_busy !== 1'b0 || mem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got busy=%b req=%b want 0 0", L2_busy, mem_req);
    end
  endtask

  task automatic test_normal();
    int lat, wl, cl;
    bit bg;
    logic [127:0] d;
    logic v;
    exp_t e;
    clear_obs();
    start_req(32'h0000_1234, -1, -1, 0);
    tick(1);
    if_addr = 32'hFFFF_FFF0;
    wait_rdy(lat, bg);
    tests_run++;
    if (lat + 1 != 9) begin
      tests_failed++;
      $display("FAIL normal_rdy_latency: got %0d want 9", lat + 1);
    end
    tests_run++;
    if (bg) begin
      tests_failed++;
      $display("FAIL normal_busy: got busy low during fetch want high");
    end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (obs_addr_q.size() <= k || obs_addr_q[k] !== 32'h1230 + 32'(4 * k)) begin
        tests_failed++;
        $display("FAIL normal_addr%0d: got %h want %h", k, (obs_addr_q.size() > k) ? obs_addr_q[k] : 32'hx, 32'h1230 + 32'(4 * k));
      end
    end
    tests_run++;
    if (l1_data_wd !== exp_q[0].line) begin
      tests_failed++;
      $display("FAIL normal_line_at_rdy: got %h want %h", l1_data_wd, exp_q[0].line);
    end
    finish_req(wl, d, v, cl);
    e = exp_q.pop_front();
    tests_run++;
    if (wl != 1 || cl != 2) begin
      tests_failed++;
      $display("FAIL normal_wr_cmp_timing: got wr=%0d cmp=%0d want 1 2", wl, cl);
    end
    tests_run++;
    if (d !== e.line || v !== e.valid) begin
      tests_failed++;
      $display("FAIL normal_write: got %h/%b want %h/%b", d, v, e.line, e.valid);
    end
    tests_run++;
    if (L2_busy !== 1'b0 || cnt_wr != 1 || cnt_cmp != 1 || refill_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL normal_end: got busy=%b wr=%0d cmp=%0d err=%b want 0 1 1 0", L2_busy, cnt_wr, cnt_cmp, refill_err);
    end
  endtask

  task automatic test_slow_mem();
    int lat, wl, cl;
    bit bg;
    logic [127:0] d;
    logic v;
    exp_t e;
    clear_obs();
    start_req(32'h0000_2000, -1, 2, 5);
    wait_rdy(lat, bg);
    tests_run++;
    if (lat != 14) begin
      tests_failed++;
      $display("FAIL slow_rdy_latency: got %0d want 14", lat);
    end
    tests_run++;
    if (run_len[2] != 6 || addr_unstable != 0) begin
      tests_failed++;
      $display("FAIL slow_req_hold: got len=%0d unstable=%0d want 6 0", run_len[2], addr_unstable);
    end
    finish_req(wl, d, v, cl);
    e = exp_q.pop_front();
    tests_run++;
    if (d !== e.line || v !== e.valid || refill_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL slow_write: got %h/%b err=%b want %h/%b err=0", d, v, refill_err, e.line, e.valid);
    end
  endtask

  task automatic test_timeout();
    int lat, wl, cl;
    bit bg;
    logic [127:0] d;
    logic v;
    exp_t e;
    clear_obs();
    start_req(32'h0000_3000, 1, -1, 0);
    wait_rdy(lat, bg);
    tests_run++;
    if (lat != 16 || run_len[1] != int'(TO)) begin
      tests_failed++;
      $display("FAIL timeout_timing: got rdy=%0d len=%0d want 16 %0d", lat, run_len[1], TO);
    end
    tests_run++;
    if (refill_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_err: got %b want 1", refill_err);
    end
    tests_run++;
    if (obs_addr_q.size() != 3 || obs_addr_q[1] !== 32'h3008 || obs_addr_q[2] !== 32'h300C) begin
      tests_failed++;
      $display("FAIL timeout_later_beats: got %0d acked beats want 3 incl 3008 300C", obs_addr_q.size());
    end
    finish_req(wl, d, v, cl);
    e = exp_q.pop_front();
    tests_run++;
    if (d !== e.line || v !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_write: got %h/%b want %h/0", d, v, e.line);
    end
  endtask

  task automatic test_abort();
    bit found;
    int busy_lat;
    clear_obs();
    start_req(32'h0000_500C, -1, 1, 3);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (mem_req === 1'b1 && mem_addr === 32'h5004) begin
        found = 1'b1;
        break;
      end
    end
    irq = 1'b0;
    void'(exp_q.pop_back());
    busy_lat = -1;
    for (int c = 1; c <= 20; c++) begin
      tick(1);
      if (L2_busy === 1'b0) begin
        busy_lat = c;
        break;
      end
    end
    tests_run++;
    if (!found || busy_lat != 4) begin
      tests_failed++;
      $display("FAIL abort_busy_fall: got found=%0d lat=%0d want 1 4", found, busy_lat);
    end
    tests_run++;
    if (obs_addr_q.size() != 2 || obs_addr_q[1] !== 32'h5004) begin
      tests_failed++;
      $display("FAIL abort_beats: got %0d acked beats want 2 ending 5004", obs_addr_q.size());
    end
    cnt_req = 0;
    tick(12);
    tests_run++;
    if (cnt_rdy != 0 || cnt_wr != 0 || cnt_cmp != 0 || cnt_req != 0) begin
      tests_failed++;
      $display("FAIL abort_quiet: got rdy=%0d wr=%0d cmp=%0d req=%0d want 0 0 0 0", cnt_rdy, cnt_wr, cnt_cmp, cnt_req);
    end
    tests_run++;
    if (refill_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_sticky: got %b want 1", refill_err);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    int lat, wl, cl;
    bit bg;
    logic [127:0] d;
    logic v;
    exp_t e;
    clear_obs();
    start_req(32'h0000_6000, 2, -1, 0);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (mem_req === 1'b1 && mem_addr === 32'h6008) begin
        found = 1'b1;
        break;
      end
    end
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (!found || {mem_req, L2_busy, L2_rdy, refill_err} !== 4'b0 || mem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mid: got found=%0d req/busy/rdy/err=%b addr=%h want 1 0000 0", found, {mem_req, L2_busy, L2_rdy, refill_err}, mem_addr);
    end
    irq = 1'b0;
    void'(exp_q.pop_back());
    tick(2);
    rst = 1'b1;
    tick(1);
    clear_obs();
    start_req(32'h0000_4000, -1, -1, 0);
    wait_rdy(lat, bg);
    tests_run++;
    if (lat != 9) begin
      tests_failed++;
      $display("FAIL reset_mid_latency: got %0d want 9", lat);
    end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (obs_addr_q.size() <= k || obs_addr_q[k] !== 32'h4000 + 32'(4 * k)) begin
        tests_failed++;
        $display("FAIL reset_mid_addr%0d: got %h want %h", k, (obs_addr_q.size() > k) ? obs_addr_q[k] : 32'hx, 32'h4000 + 32'(4 * k));
      end
    end
    finish_req(wl, d, v, cl);
    e = exp_q.pop_front();
    tests_run++;
    if (d !== e.line || v !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_write: got %h/%b want %h/1", d, v, e.line);
    end
  endtask

  task automatic test_back_to_back();
    int lat, gap;
    bit bg, got_cmp;
    logic [127:0] d1, d2;
    logic v1, v2;
    exp_t e;
    clear_obs();
    start_req(32'h0000_7000, -1, -1, 0);
    wait_rdy(lat, bg);
    irq = 1'b0;
    d1 = '0; v1 = 1'b0; got_cmp = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      if (l1_wr_en === 1'b1) begin
        d1 = l1_data_wd;
        v1 = l1_valid_wd;
      end
      if (complete === 1'b1) begin
        got_cmp = 1'b1;
        break;
      end
    end
    start_req(32'h0000_8010, -1, -1, 0);
    gap = -1; d2 = '0; v2 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick(1);
      if (L2_rdy === 1'b1) irq = 1'b0;
      if (l1_wr_en === 1'b1) begin
        d2 = l1_data_wd;
        v2 = l1_valid_wd;
      end
      if (complete === 1'b1) begin
        gap = c;
        break;
      end
    end
    irq = 1'b0;
    tick(1);
    e = exp_q.pop_front();
    tests_run++;
    if (!got_cmp || d1 !== e.line || v1 !== e.valid) begin
      tests_failed++;
      $display("FAIL b2b_first: got cmp=%0d %h/%b want 1 %h/%b", got_cmp, d1, v1, e.line, e.valid);
    end
    e = exp_q.pop_front();
    tests_run++;
    if (d2 !== e.line || v2 !== e.valid) begin
      tests_failed++;
      $display("FAIL b2b_second: got %h/%b want %h/%b", d2, v2, e.line, e.valid);
    end
    tests_run++;
    if (gap != 12) begin
      tests_failed++;
      $display("FAIL b2b_gap: got %0d want 12", gap);
    end
    tests_run++;
    if (exp_q.size() != 0 || cnt_wr != 2 || cnt_cmp != 2) begin
      tests_failed++;
      $display("FAIL b2b_counts: got left=%0d wr=%0d cmp=%0d want 0 2 2", exp_q.size(), cnt_wr, cnt_cmp);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_slow_mem();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
